// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared state encoding, master IDs and default widths for the RAM port-2 arbiter
package comm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_XFER,
    ST_DMA_XFER,
    ST_DMA_HOLD
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam int ADDR_W_DEF        = 16;
  localparam int DATA_W_DEF        = 32;
  localparam int TIMEOUT_DEF       = 15;
  localparam int DMA_MAX_BURST_DEF = 8;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-request round-robin pick; on a tie the master that was not granted last wins
module arb_rr2
  import comm_pkg::*;
(
  input  logic req_cpu,
  input  logic req_dma,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  always_comb begin
    valid = req_cpu | req_dma;
    if (req_cpu && req_dma) begin
      grant = (last_grant == M_CPU) ? M_DMA : M_CPU;
    end else if (req_dma) begin
      grant = M_DMA;
    end else begin
      grant = M_CPU;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares RAM port 2 between CPU data and DMA master with burst lock and ack timeout
module ram_port_arbiter
  import comm_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF,
  parameter int DMA_MAX_BURST = DMA_MAX_BURST_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cpu_stb_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_ack_o,
  output logic              cpu_err_o,
  input  logic              dma_cyc_i,
  input  logic              dma_stb_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_data_i,
  output logic [DATA_W-1:0] dma_data_o,
  output logic              dma_ack_o,
  output logic              dma_err_o,
  output logic              ram_stb_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic              ram_ack_i,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam int BW = $clog2(DMA_MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT);

  state_t        state;
  logic          last_grant;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] to_cnt;
  logic          grant_valid;
  logic          grant;

  logic in_cpu, in_dma, timeout, burst_full;

  assign in_cpu     = (state == ST_CPU_XFER);
  assign in_dma     = (state == ST_DMA_XFER);
  assign timeout    = (in_cpu | in_dma) & ~ram_ack_i & (to_cnt == TW'(TIMEOUT - 1));
  assign burst_full = (beat_cnt == BW'(DMA_MAX_BURST));

  arb_rr2 u_arb (
    .req_cpu    (cpu_stb_i),
    .req_dma    (dma_cyc_i & dma_stb_i),
    .last_grant (last_grant),
    .valid      (grant_valid),
    .grant      (grant)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= ST_IDLE;
      last_grant <= M_DMA;
      beat_cnt   <= '0;
      to_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          beat_cnt <= '0;
          to_cnt   <= '0;
          if (grant_valid) state <= (grant == M_CPU) ? ST_CPU_XFER : ST_DMA_XFER;
        end
        ST_CPU_XFER: begin
          if (ram_ack_i || timeout) begin
            state      <= ST_IDLE;
            last_grant <= M_CPU;
            beat_cnt   <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DMA_XFER: begin
          if (ram_ack_i) begin
            // Saturate so a long uncontended burst still matches the limit once the CPU shows up.
            if (!burst_full) beat_cnt <= beat_cnt + 1'b1;
            last_grant <= M_DMA;
            state      <= ST_DMA_HOLD;
          end else if (timeout) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DMA_HOLD: begin
          to_cnt <= '0;
          if (!dma_cyc_i || (cpu_stb_i && burst_full)) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
          end else if (dma_stb_i) begin
            state <= ST_DMA_XFER;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_stb_o  = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (in_cpu) begin
      ram_stb_o  = cpu_stb_i & ~timeout;
      ram_we_o   = cpu_we_i;
      ram_addr_o = cpu_addr_i;
      ram_data_o = cpu_data_i;
    end else if (in_dma) begin
      ram_stb_o  = dma_stb_i & ~timeout;
      ram_we_o   = dma_we_i;
      ram_addr_o = dma_addr_i;
      ram_data_o = dma_data_i;
    end
  end

  assign cpu_ack_o  = in_cpu & ram_ack_i;
  assign cpu_err_o  = in_cpu & timeout;
  assign cpu_data_o = in_cpu ? ram_data_i : '0;
  assign dma_ack_o  = in_dma & ram_ack_i;
  assign dma_err_o  = in_dma & timeout;
  assign dma_data_o = in_dma ? ram_data_i : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed vector table plus hand sequences for burst lock, timeout and reset
module tb_ram_port_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        cpu_stb = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_err;
  logic        dma_cyc = 1'b0, dma_stb = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [31:0] dma_wdata = '0;
  logic [31:0] dma_rdata;
  logic        dma_ack, dma_err;
  logic        ram_stb, ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ack = 1'b0;
  logic [31:0] ram_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  ram_port_arbiter dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cpu_stb_i  (cpu_stb),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_wdata),
    .cpu_data_o (cpu_rdata),
    .cpu_ack_o  (cpu_ack),
    .cpu_err_o  (cpu_err),
    .dma_cyc_i  (dma_cyc),
    .dma_stb_i  (dma_stb),
    .dma_we_i   (dma_we),
    .dma_addr_i (dma_addr),
    .dma_data_i (dma_wdata),
    .dma_data_o (dma_rdata),
    .dma_ack_o  (dma_ack),
    .dma_err_o  (dma_err),
    .ram_stb_o  (ram_stb),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_data_o (ram_wdata),
    .ram_ack_i  (ram_ack),
    .ram_data_i (ram_rdata)
  );

  typedef struct {
    logic        cs, cw;
    logic [15:0] ca;
    logic [31:0] cd;
    logic        dc, ds, dw;
    logic [15:0] da;
    logic [31:0] dd;
    logic        ack;
    logic [31:0] rd;
    logic [117:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [117:0] mk(logic s, logic w, logic [15:0] a, logic [31:0] d,
                                      logic ca, logic ce, logic [31:0] cd,
                                      logic da, logic de, logic [31:0] dd);
    return {s, w, a, d, ca, ce, cd, da, de, dd};
  endfunction

  function automatic logic [117:0] outs();
    return {ram_stb, ram_we, ram_addr, ram_wdata, cpu_ack, cpu_err, cpu_rdata, dma_ack, dma_err, dma_rdata};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    cpu_stb = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_cyc = 1'b0; dma_stb = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    ram_ack = 1'b0; ram_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
  endtask

  int beats, c_cnt, d_before, d_after, b2b, ok_cnt;
  logic prev_stb;

  initial begin
    // reset, tie, hold with cyc drop, then single CPU read
    vecs[0] = '{1'b1, 1'b1, 16'h0020, 32'h1, 1'b1, 1'b1, 1'b1, 16'h0030, 32'h2, 1'b0, 32'h0,
                mk(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0)};
    vecs[1] = '{1'b1, 1'b1, 16'h0020, 32'h1, 1'b1, 1'b1, 1'b1, 16'h0030, 32'h2, 1'b1, 32'h0,
                mk(1'b1, 1'b1, 16'h0020, 32'h1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0)};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b1, 1'b1, 16'h0030, 32'h2, 1'b0, 32'h0,
                mk(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0)};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b1, 1'b1, 16'h0030, 32'h2, 1'b1, 32'h55,
                mk(1'b1, 1'b1, 16'h0030, 32'h2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h55)};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h0,
                mk(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0)};
    vecs[5] = '{1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h0,
                mk(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0)};
    vecs[6] = '{1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 32'hDEADBEEF,
                mk(1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0)};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 32'hDEADBEEF,
                mk(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0)};

    clear_inputs();
    #2;
    check("reset_state", outs(), '0);
    do_reset();

    foreach (vecs[i]) begin
      @(negedge sys_clk);
      cpu_stb = vecs[i].cs; cpu_we = vecs[i].cw; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
      dma_cyc = vecs[i].dc; dma_stb = vecs[i].ds; dma_we = vecs[i].dw;
      dma_addr = vecs[i].da; dma_wdata = vecs[i].dd;
      ram_ack = vecs[i].ack; ram_rdata = vecs[i].rd;
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // 12-beat DMA burst, CPU waiting from the first beat on
    do_reset();
    beats = 0; c_cnt = 0; d_before = 0; d_after = 0; b2b = 0; prev_stb = 1'b0;
    dma_cyc = 1'b1; dma_stb = 1'b1; dma_addr = 16'h0100; ram_ack = 1'b1; ram_rdata = 32'h1234;
    for (int cyc = 0; cyc < 200 && beats < 12; cyc++) begin
      @(negedge sys_clk);
      #1;
      if (ram_stb && prev_stb) b2b++;
      prev_stb = ram_stb;
      if (cpu_ack) begin
        c_cnt++;
        cpu_stb = 1'b0;
      end
      if (dma_ack) begin
        beats++;
        if (c_cnt == 0) d_before++; else d_after++;
        dma_addr = dma_addr + 16'h1;
        if (beats == 12) begin dma_cyc = 1'b0; dma_stb = 1'b0; end
      end
      if (beats >= 1 && c_cnt == 0 && !cpu_ack) cpu_stb = 1'b1;
    end
    check("burst_total", beats, 12);
    check("burst_before_cpu", d_before, 8);
    check("burst_cpu_xfers", c_cnt, 1);
    check("burst_after_cpu", d_after, 4);
    check("stb_gap", b2b, 0);

    // CPU timeout with no RAM ack, then a normal DMA grant
    do_reset();
    @(negedge sys_clk);
    cpu_stb = 1'b1; cpu_addr = 16'h0040; ram_ack = 1'b0;
    #1;
    ok_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge sys_clk); #1;
      if (ram_stb && !cpu_err && !cpu_ack) ok_cnt++;
    end
    check("to_wait_cycles", ok_cnt, 14);
    @(negedge sys_clk); #1;
    check("to_err_cycle", {cpu_err, ram_stb, dma_err, cpu_ack}, 4'b1000);
    cpu_stb = 1'b0; dma_cyc = 1'b1; dma_stb = 1'b1; dma_addr = 16'h0050; ram_ack = 1'b1;
    @(negedge sys_clk); #1;
    check("to_then_idle", {ram_stb, cpu_err}, 2'b00);
    @(negedge sys_clk); #1;
    check("to_dma_grant", {ram_stb, dma_ack, ram_addr}, {1'b1, 1'b1, 16'h0050});
    dma_cyc = 1'b0; dma_stb = 1'b0;

    // RAM ack lands exactly in the 15th transfer cycle
    do_reset();
    @(negedge sys_clk);
    cpu_stb = 1'b1; cpu_addr = 16'h0044; ram_ack = 1'b0; ram_rdata = 32'hA5A5A5A5;
    ok_cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge sys_clk);
      ram_ack = (k == 15);
      #1;
      if (k < 15 && ram_stb && !cpu_err) ok_cnt++;
    end
    check("ackto_wait", ok_cnt, 14);
    check("ackto_ack_wins", {cpu_ack, cpu_err, ram_stb, cpu_rdata}, {1'b1, 1'b0, 1'b1, 32'hA5A5A5A5});
    cpu_stb = 1'b0; ram_ack = 1'b0;
    @(negedge sys_clk); #1;
    check("ackto_after", {cpu_err, ram_stb, cpu_ack}, 3'b000);

    // asynchronous reset in the middle of a DMA transfer
    do_reset();
    @(negedge sys_clk);
    dma_cyc = 1'b1; dma_stb = 1'b1; dma_we = 1'b1; dma_addr = 16'h0060; dma_wdata = 32'h7; ram_ack = 1'b0;
    @(negedge sys_clk); #1;
    check("rst_pre_xfer", {ram_stb, ram_addr}, {1'b1, 16'h0060});
    #1;
    sys_rst = 1'b0; ram_ack = 1'b1; ram_rdata = 32'hFFFF0000;
    #1;
    check("rst_async_outs", outs(), '0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0070; cpu_wdata = 32'h9;
    @(negedge sys_clk); #1;
    check("rst_tie_cpu", {ram_stb, ram_addr, cpu_ack, dma_ack}, {1'b1, 16'h0070, 1'b1, 1'b0});
    cpu_stb = 1'b0;

    // cyc dropped in DMA_HOLD with a CPU request pending
    @(negedge sys_clk); #1;
    check("cyc_idle_gap", ram_stb, 1'b0);
    @(negedge sys_clk); #1;
    check("cyc_dma_beat", {ram_stb, dma_ack, ram_addr}, {1'b1, 1'b1, 16'h0060});
    dma_stb = 1'b0;
    @(negedge sys_clk);
    dma_cyc = 1'b0;
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0080;
    #1;
    check("cyc_hold_quiet", {ram_stb, cpu_ack, dma_ack}, 3'b000);
    @(negedge sys_clk); #1;
    check("cyc_idle_next", ram_stb, 1'b0);
    @(negedge sys_clk); #1;
    check("cyc_cpu_grant", {ram_stb, ram_addr, cpu_ack}, {1'b1, 16'h0080, 1'b1});
    cpu_stb = 1'b0;

    @(negedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
